// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and
// queues returned words for decode. Optional IF_PERF_EN adds FetchCount/BubbleCount.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC_IF,
  output logic        Discard_ID
`ifdef IF_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   word_mem_q [DEPTH];

  logic          issue, resp, drop, push, pop, head_valid;
  logic [CW:0]   credit_used;

  // Handshake: a request is issued on a cycle with imem_req & imem_gnt; imem_addr
  // must hold while imem_req is high and ungranted. Each issued request returns
  // exactly one imem_rvalid beat, in issue order, at least one cycle later.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req    = !Redirect && (credit_used < DEPTH_W);
  assign imem_addr   = fpc_q;
  assign issue       = imem_req && imem_gnt;

  // A beat with nothing outstanding is a protocol error and is ignored.
  assign resp = imem_rvalid && (outstanding_q != '0);
  assign drop = resp && (drop_q != '0);
  assign push = resp && !drop && !Redirect;

  assign head_valid  = (count_q != '0) && !Redirect;
  assign pop         = head_valid && !Stall;
  assign Discard_ID  = !head_valid;
  assign Instruction = head_valid ? word_mem_q[head_q] : NOP;
  assign PC_IF       = head_valid ? pc_mem_q[head_q] : 32'h0;

  always_comb begin
    fpc_d         = fpc_q;
    rpc_d         = rpc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    if (Redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      fpc_d         = RedirectPC;
      rpc_d         = RedirectPC;
      outstanding_d = outstanding_q - CW'(resp);
      drop_d        = outstanding_q - CW'(resp);
      count_d       = '0;
      head_d        = '0;
      tail_d        = '0;
    end else begin
      if (issue) fpc_d = fpc_q + 32'd4;
      outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
      if (drop) drop_d = drop_q - CW'(1);
      if (push) begin
        rpc_d  = rpc_q + 32'd4;
        tail_d = tail_q + AW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fpc_q         <= RESET_PC;
      rpc_q         <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      fpc_q         <= fpc_d;
      rpc_q         <= rpc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // Queue storage needs no reset: entries are only read while count_q covers them.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[tail_q]   <= rpc_q;
      word_mem_q[tail_q] <= imem_rdata;
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (pop)        fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (Discard_ID) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random grant/latency and a
// PC-stream reference model of what decode must see.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        Stall, Redirect;
  logic [31:0] RedirectPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction, PC_IF;
  logic        Discard_ID;
`ifdef IF_PERF_EN
  logic [31:0] FetchCount, BubbleCount;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clock(clock), .reset(reset), .Stall(Stall), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .PC_IF(PC_IF), .Discard_ID(Discard_ID)
`ifdef IF_PERF_EN
    , .FetchCount(FetchCount), .BubbleCount(BubbleCount)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int gnt_pct = 100;
  int rv_pct = 100;
  int cyc, epoch, delivered, bubbles;
  logic [31:0] exp_fpc;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_ep[$];
  int          pend_cyc[$];
  logic [31:0] last_pc, last_addr;
  logic        last_disc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_addr.delete();
    pend_ep.delete();
    pend_cyc.delete();
    exp_fpc   = RESET_PC;
    cyc       = 0;
    delivered = 0;
    bubbles   = 0;
    epoch++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    chk("rst_discard", {31'b0, Discard_ID}, 32'd1);
    chk("rst_instr", Instruction, NOP);
    chk("rst_pc_if", PC_IF, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, RESET_PC);
`ifdef IF_PERF_EN
    chk("rst_fetch_cnt", FetchCount, 32'h0);
    chk("rst_bubble_cnt", BubbleCount, 32'h0);
`endif
    model_clear();
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic        gnt, rv, exp_req, exp_disc;
    logic [31:0] a;
    int          e, infl;
    @(negedge clock);
    gnt = ($urandom_range(99) < gnt_pct);
    rv  = (pend_addr.size() > 0) && (pend_cyc[0] < cyc) && ($urandom_range(99) < rv_pct);
    Stall = st; Redirect = rd; RedirectPC = rpc;
    imem_gnt = gnt; imem_rvalid = rv;
    imem_rdata = rv ? pend_addr[0] + 32'h100 : $urandom;
    #1;
    infl     = pend_addr.size();
    exp_req  = !rd && (infl + exp_q.size() < DEPTH);
    exp_disc = rd || (exp_q.size() == 0);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("imem_addr", imem_addr, exp_fpc);
    chk("discard", {31'b0, Discard_ID}, {31'b0, exp_disc});
    if (!exp_disc) begin
      chk("pc_if", PC_IF, exp_q[0]);
      chk("instr", Instruction, exp_q[0] + 32'h100);
    end else begin
      chk("bubble_pc_if", PC_IF, 32'h0);
      chk("bubble_instr", Instruction, NOP);
    end
    tests++;
    assert (infl + exp_q.size() <= DEPTH) else begin
      fails++;
      $error("FAIL credit: got %0d expected <= %0d", infl + exp_q.size(), DEPTH);
    end
`ifdef IF_PERF_EN
    chk("fetch_cnt", FetchCount, delivered);
    chk("bubble_cnt", BubbleCount, bubbles);
`endif
    last_pc   = PC_IF;
    last_disc = Discard_ID;
    last_addr = imem_addr;
    if (!exp_disc && !st) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (exp_disc) bubbles++;
    if (rv) begin
      a = pend_addr.pop_front();
      e = pend_ep.pop_front();
      void'(pend_cyc.pop_front());
      if (!rd && e == epoch) exp_q.push_back(a);
    end
    if (rd) begin
      exp_q.delete();
      exp_fpc = rpc;
      epoch++;
    end else if (exp_req && gnt) begin
      pend_addr.push_back(exp_fpc);
      pend_ep.push_back(epoch);
      pend_cyc.push_back(cyc);
      exp_fpc = exp_fpc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    logic        found;
    logic [31:0] addr0, raddr;
    logic        st, rd;
    reset = 1'b0;
    epoch = 0;
    do_reset();

    // Reset exit with an ideal 1-cycle memory: two bubbles, then one PC per cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (i < 2) chk("exit_bubble", {31'b0, last_disc}, 32'd1);
      else chk("stream_pc", last_pc, 32'((i - 2) * 4));
    end

    // Redirect from steady state: 3-cycle penalty.
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    chk("redir_t1", {31'b0, last_disc}, 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("redir_t2", {31'b0, last_disc}, 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("redir_t3_disc", {31'b0, last_disc}, 32'd0);
    chk("redir_t3_pc", last_pc, 32'h40);

    // Stall for 3 cycles while 0x8 is at the head.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(i >= 4 && i <= 6, 1'b0, 32'h0);
      if (i >= 4 && i <= 7) chk("stall_hold", last_pc, 32'h8);
      if (i == 8) chk("stall_next", last_pc, 32'hC);
    end

    // Redirect with several requests still outstanding.
    rv_pct = 0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    rv_pct = 100;
    step(1'b0, 1'b1, 32'h80);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b0, 32'h0);
      found = !last_disc;
    end
    chk("late_drop_found", {31'b0, found}, 32'd1);
    chk("late_drop_pc", last_pc, 32'h80);

    // Redirect together with Stall while the queue is full of valid entries.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b0, 32'h0);
      found = !last_disc;
    end
    chk("redir_stall_found", {31'b0, found}, 32'd1);
    chk("redir_stall_pc", last_pc, 32'h200);

    // Grant withheld: address holds and the queue drains to bubbles.
    gnt_pct = 0;
    step(1'b0, 1'b0, 32'h0);
    addr0 = last_addr;
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 32'h0);
    chk("gnt_low_addr", last_addr, addr0);
    chk("gnt_low_drain", {31'b0, last_disc}, 32'd1);

    // Fetch PC wrap across the top of the address space.
    gnt_pct = 100;
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0);

    // Randomised traffic, with a reset in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      gnt_pct = 40 + 20 * ((i / 100) % 4);
      rv_pct  = 30 + 25 * ((i / 150) % 3);
      st      = ($urandom_range(99) < 25);
      rd      = ($urandom_range(99) < 4);
      raddr   = $urandom() & 32'hFFFF_FFFC;
      step(st, rd, raddr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
